// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 game-key tracker: key indices, scan codes,
// event layout and the {expand, code} -> key index decoder.
package ps2_key_pkg;

    // Event word {repeat, make, key_idx[2:0]}
    localparam int unsigned EVT_W          = 5;
    localparam int unsigned EVT_REPEAT_BIT = 4;
    localparam int unsigned EVT_MAKE_BIT   = 3;
    localparam int unsigned EVT_IDX_LSB    = 0;
    localparam int unsigned EVT_IDX_W      = 3;

    // Key indices (bit positions in key_held)
    localparam logic [2:0] KEY_W     = 3'd0;
    localparam logic [2:0] KEY_A     = 3'd1;
    localparam logic [2:0] KEY_S     = 3'd2;
    localparam logic [2:0] KEY_D     = 3'd3;
    localparam logic [2:0] KEY_UP    = 3'd4;
    localparam logic [2:0] KEY_LEFT  = 3'd5;
    localparam logic [2:0] KEY_DOWN  = 3'd6;
    localparam logic [2:0] KEY_RIGHT = 3'd7;

    // Scan codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Expand (E0) prefix flags
    localparam logic EXP_NONE = 1'b0;
    localparam logic EXP_E0   = 1'b1;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_dec_t;

    // Expand bit must match exactly; anything else is unmapped
    function automatic key_dec_t decode_key(input logic expand, input logic [7:0] code);
        key_dec_t d;
        d.hit = 1'b1;
        d.idx = KEY_W;
        case ({expand, code})
            {EXP_NONE, SC_W}:     d.idx = KEY_W;
            {EXP_NONE, SC_A}:     d.idx = KEY_A;
            {EXP_NONE, SC_S}:     d.idx = KEY_S;
            {EXP_NONE, SC_D}:     d.idx = KEY_D;
            {EXP_E0,   SC_UP}:    d.idx = KEY_UP;
            {EXP_E0,   SC_LEFT}:  d.idx = KEY_LEFT;
            {EXP_E0,   SC_DOWN}:  d.idx = KEY_DOWN;
            {EXP_E0,   SC_RIGHT}: d.idx = KEY_RIGHT;
            default:              d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO with simultaneous read/write and a
// sticky overflow flag set whenever a write is dropped on full.
module key_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         overflow,
    input  logic         ovf_clr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_rd, do_wr, drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && full && !do_rd;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Game-key tracker downstream of the PS/2 receiver: held-key bitmap,
// per-key press/release pulses and an event FIFO for the game FSM.
// Optional macro KEY_AUTOREPEAT_EN: typematic makes of a held key queue
// a repeat event {1,1,idx}; otherwise they are discarded.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       kb_data,
    input  logic             kb_ready,
    output logic [7:0]       key_held,
    output logic [7:0]       key_press,
    output logic [7:0]       key_release,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_rd,
    output logic             overflow,
    input  logic             ovf_clr
);

    key_dec_t         dec;
    logic [7:0]       held_nxt;
    logic             push;
    logic [EVT_W-1:0] push_evt;
    logic             fifo_empty;

    assign dec = decode_key(kb_data[9], kb_data[7:0]);

    // Decode one strobe into the next bitmap and at most one event
    always_comb begin
        held_nxt = key_held;
        push     = 1'b0;
        push_evt = '0;
        push_evt[EVT_IDX_LSB +: EVT_IDX_W] = dec.idx;
        if (kb_ready && dec.hit) begin
            if (!kb_data[8]) begin
                if (!key_held[dec.idx]) begin
                    held_nxt[dec.idx]      = 1'b1;
                    push                   = 1'b1;
                    push_evt[EVT_MAKE_BIT] = 1'b1;
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    push                     = 1'b1;
                    push_evt[EVT_MAKE_BIT]   = 1'b1;
                    push_evt[EVT_REPEAT_BIT] = 1'b1;
`endif
                end
            end else if (key_held[dec.idx]) begin
                held_nxt[dec.idx] = 1'b0;
                push              = 1'b1;
            end
        end
    end

    // Bitmap register; pulses are the edges of the bitmap update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_held    <= held_nxt;
            key_press   <= held_nxt & ~key_held;
            key_release <= ~held_nxt & key_held;
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (push_evt),
        .rd_en    (evt_rd),
        .rd_data  (evt_data),
        .empty    (fifo_empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    assign evt_valid = !fifo_empty;

endmodule
